// File: rtl/arb2_mux_ctrl_if.sv
// ----------------------------------------------------------------------------
// arb2_mux_ctrl_if
// Handshake and data bundle between two requesters and the 2:1 arbitrated
// mux controller.
//   req0/req1   : requester wants the shared path
//   done0/done1 : granted requester releases the path (one-cycle pulse)
//   d0/d1       : requester data (W bits)
//   gnt0/gnt1   : registered grants, one-hot or zero
//   sel         : registered mux select (0 -> d0, 1 -> d1)
//   dout        : shared path output, zero when nobody is granted
//   busy        : either grant active
//   timeout     : one-cycle pulse after a forced (hold-limit) release
// master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface arb2_mux_ctrl_if #(
    parameter int W = 8
);
    logic         req0;
    logic         req1;
    logic         done0;
    logic         done1;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         gnt0;
    logic         gnt1;
    logic         sel;
    logic [W-1:0] dout;
    logic         busy;
    logic         timeout;

    modport master (
        output req0, req1, done0, done1, d0, d1,
        input  gnt0, gnt1, sel, dout, busy, timeout
    );

    modport slave (
        input  req0, req1, done0, done1, d0, d1,
        output gnt0, gnt1, sel, dout, busy, timeout
    );
endinterface

// File: rtl/arb2_mux_ctrl.sv
// ----------------------------------------------------------------------------
// arb2_mux_ctrl
// Two-requester round-robin arbiter driving a 2:1 data mux. A grant is held
// until the owner pulses done, drops its request, or has held the path for
// MAX_HOLD consecutive cycles (forced release, flagged by timeout).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : arb2_mux_ctrl_if slave modport (requests, data, grants, mux out)
// ----------------------------------------------------------------------------
module arb2_mux_ctrl #(
    parameter int W        = 8,
    parameter int MAX_HOLD = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    arb2_mux_ctrl_if.slave    bus
);
    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] LIM = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          sel_q, sel_d;
    logic          tmo_q, tmo_d;

    logic          lim;
    logic          rel0, rel1;
    logic [W-1:0]  mux_w;

    assign lim  = (cnt_q == LIM);
    assign rel0 = bus.done0 | ~bus.req0 | lim;
    assign rel1 = bus.done1 | ~bus.req1 | lim;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        last_d  = last_q;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // Tie goes to whoever was not served last.
                if (bus.req0 && bus.req1)
                    state_d = last_q ? GRANT0 : GRANT1;
                else if (bus.req0)
                    state_d = GRANT0;
                else if (bus.req1)
                    state_d = GRANT1;
            end
            GRANT0: begin
                if (rel0) begin
                    last_d  = 1'b0;
                    state_d = bus.req1 ? GRANT1 : IDLE;
                    // Only a pure hold-limit release is a timeout.
                    tmo_d   = lim & bus.req0 & ~bus.done0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GRANT1: begin
                if (rel1) begin
                    last_d  = 1'b1;
                    state_d = bus.req0 ? GRANT0 : IDLE;
                    tmo_d   = lim & bus.req1 & ~bus.done1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Select follows the granted side and holds through IDLE.
        sel_d = sel_q;
        case (state_d)
            GRANT0:  sel_d = 1'b0;
            GRANT1:  sel_d = 1'b1;
            default: sel_d = sel_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            tmo_q   <= tmo_d;
        end
    end

    assign bus.gnt0    = (state_q == GRANT0);
    assign bus.gnt1    = (state_q == GRANT1);
    assign bus.busy    = bus.gnt0 | bus.gnt1;
    assign bus.sel     = sel_q;
    assign bus.timeout = tmo_q;

    assign mux_w    = sel_q ? bus.d1 : bus.d0;
    assign bus.dout = bus.busy ? mux_w : '0;

endmodule

// File: doc/arb2_mux_ctrl.md
ARB2_MUX_CTRL -- requirements
Module: arb2_mux_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the shared data width in bits.
REQ-002 The block SHALL have parameter MAX_HOLD, default 15, giving the maximum consecutive grant cycles before forced release (legal range 2..255).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low, ports named clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req0 / req1  input  1 each  requester 0 / requester 1 wants the shared path.
REQ-007 done0 / done1  input  1 each  granted requester releases the path (one-cycle pulse).
REQ-008 d0 / d1  input  W each  requester data.
REQ-009 gnt0 / gnt1  output  1 each  registered grant, one-hot or zero.
REQ-010 sel  output  1  registered 2:1 select: 0 routes d0, 1 routes d1.
REQ-011 dout  output  W  shared path output.
REQ-012 busy  output  1  high while either grant is active.
REQ-013 timeout  output  1  one-cycle pulse on forced release.

Function
REQ-014 The block SHALL implement states IDLE, GRANT0 and GRANT1, plus a one-bit last-served pointer `last` and a hold counter of ceil(log2(MAX_HOLD)) bits.
REQ-015 In IDLE, with req0 only, the next state SHALL be GRANT0; with req1 only, GRANT1; with both, the requester not equal to `last`; with neither, IDLE.
REQ-016 Grant latency SHALL be exactly one cycle: a request sampled at edge k gives a grant visible after edge k.
REQ-017 gnt0 SHALL equal (state==GRANT0), gnt1 SHALL equal (state==GRANT1), and busy SHALL equal gnt0|gnt1; gnt0 and gnt1 SHALL never be high together.
REQ-018 sel SHALL be 1 in GRANT1, 0 in GRANT0, and SHALL hold its previous value in IDLE.
REQ-019 dout SHALL be combinational: (sel ? d1 : d0) when busy, else all zeros.
REQ-020 In GRANTx, a release event SHALL be any of: done_x=1, req_x=0, or hold counter == MAX_HOLD-1.
REQ-021 On a release from GRANTx, `last` SHALL become x; the next state SHALL be GRANT(other) if req(other)=1, else IDLE, including when req_x is still high.
REQ-022 The switch GRANT0->GRANT1 (and the reverse) SHALL occur with no IDLE cycle: gnt drops and the other gnt rises on the same edge.
REQ-023 The hold counter SHALL load 0 on every entry to a GRANT state and in IDLE, and SHALL increment by 1 each cycle a grant is held without release.
REQ-024 timeout SHALL pulse high for exactly the one cycle following a release caused only by the counter (done_x=0 and req_x=1 at that edge).
REQ-025 done_y from the non-granted requester, or any done in IDLE, SHALL be ignored.
REQ-026 If done_x and the counter limit coincide, the release SHALL be treated as a normal release and timeout SHALL stay 0.

Reset
REQ-027 While rst_n=0, state SHALL be IDLE, gnt0=gnt1=0, busy=0, sel=0, timeout=0, hold counter=0 and last=1, so that requester 0 wins the first tie.
REQ-028 Assertion of rst_n mid-grant SHALL drop gnt and busy immediately without waiting for clk; dout SHALL then read 0.
REQ-029 After rst_n deasserts, the first grant SHALL follow the REQ-015 rules with last=1.

Verification
REQ-030 Reset release, then req0=req1=1 at the same edge -> gnt0=1 and sel=0 next cycle; dout=d0 (d0=8'hA5 -> dout=8'hA5).
REQ-031 In GRANT0 with req1 held, pulse done0 -> at the next edge gnt0=0 and gnt1=1, sel=1, no IDLE cycle, dout=d1 (8'h3C).
REQ-032 Single requester req1 held with no done, MAX_HOLD=15 -> gnt1 high for exactly 15 cycles, then one timeout pulse, one IDLE cycle (busy=0, dout=0), then gnt1 again.
REQ-033 Alternating contention with both req held and done pulsed every 3rd grant cycle -> grants strictly alternate 0,1,0,1 and the counts are equal over 20 grants.
REQ-034 done1 pulsed while gnt0 is active, and done0 pulsed in IDLE -> no state change.
REQ-035 rst_n driven low asynchronously between edges during GRANT1 -> gnt1, busy and sel go to 0 before the next edge; after release, req0=req1=1 grants requester 0 first.
